inv_clarke_pwm_ref: RTL and testbench
=====================================

# inv_clarke_pwm_ref

Inverse Clarke stage that sits directly upstream of the three-phase triangle-carrier PWM comparator. It takes an alpha/beta voltage reference in the PWM's 24-bit sign-magnitude format and computes the phase references Ua/Ub/Uc. It clamps each phase to the carrier peak and holds the results in shadow registers. The shadow registers update the PWM inputs only on a carrier sync pulse, so phase references never change mid-carrier-slope.

## Interface
Parameters:
- K_SQRT3_2, 16'hDDB4, sqrt(3)/2 as unsigned Q0.16.
- MAG_MAX, 23'h22BF10, phase magnitude clamp; equals the carrier peak of 555.94140625.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, synchronous, active-high reset.
- in_valid, input, 1, v_alpha/v_beta valid.
- in_ready, output, 1, block can accept a new reference; registered.
- v_alpha, input, 24, alpha voltage in sign-magnitude: [23] sign (1 = negative), [22:12] integer, [11:0] fraction.
- v_beta, input, 24, beta voltage, same format.
- sync, input, 1, one-cycle carrier turning-point pulse from the PWM.
- Ua, output, 24, phase A reference, same format.
- Ub, output, 24, phase B reference, same format.
- Uc, output, 24, phase C reference, same format.
- update, output, 1, one-cycle pulse in the cycle the outputs take new values.
- sat, output, 3, per-phase clamp flags for the values currently on the outputs; [0]=A, [1]=B, [2]=C.

## Operation
- Equations:
  - Ua = alpha
  - Ub = -alpha/2 + K*beta
  - Uc = -alpha/2 - K*beta
- Arithmetic and width rules:
  - alpha/2 is the 23-bit magnitude shifted right by 1, truncated toward zero, with the sign kept.
  - K*beta is (|beta| * K_SQRT3_2) as a 39-bit product, shifted right 16, floored, giving a 23-bit magnitude; the beta sign is kept.
  - Sums are formed in 25-bit two's complement and cannot overflow.
  - Each result is converted back to sign-magnitude.
  - A magnitude above MAG_MAX is set to MAG_MAX and the phase's sat bit is set; the sign is kept.
  - Negative zero (sign 1, magnitude 0) is normalized to 24'h000000. This applies to Ua as well.
- State machine:
  - IDLE: in_ready=1. On in_valid & in_ready, latch v_alpha/v_beta and go to MUL.
  - MUL: register the beta product; go to SUM.
  - SUM: register the two's-complement Ub and Uc sums and alpha; go to SAT.
  - SAT: clamp and normalize into the pending registers and pending sat flags; go to PEND.
  - PEND: wait for sync. On sync, copy pending into Ua/Ub/Uc/sat, assert update, go to IDLE.
- in_ready is 0 in every state except IDLE. No new reference is accepted until the previous one has been applied.
- sync is ignored in IDLE, MUL, SUM and SAT. Outputs hold their values until a sync arrives in PEND.
- in_valid is ignored when in_ready=0.

## Timing
- Reset values:
  - Ua=Ub=Uc=24'h000000, sat=3'b000, update=0, in_ready=0, state IDLE.
  - in_ready rises 1 clock after reset deasserts.
- Handshake: the transfer happens at edge T0, where in_valid=in_ready=1. in_ready is 0 from T0+1.
- Pipeline: MUL at T1, SUM at T2, SAT at T3. The pending registers hold valid data after edge T3.
- Output: the earliest apply is a sync sampled at edge T4.
  - Outputs change after that edge, and update=1 for exactly that one cycle.
  - in_ready=1 from the same edge.
- Sync in the same cycle as the SAT→PEND transition (edge T3) is ignored; the block waits for the next sync.
- Reset mid-operation (any state) takes effect at the next edge:
  - Pending data is discarded.
  - All outputs return to their reset values.
  - No update pulse.
- update is never asserted for two consecutive cycles.

## Test plan
- Pure alpha: v_alpha=24'h064000 (+100.0), v_beta=0, then sync -> Ua=24'h064000, Ub=Uc=24'h832000 (-50.0), sat=000, update one cycle.
- Pure beta: v_alpha=0, v_beta=24'h064000 -> Ua=24'h000000, Ub=24'h0569A5, Uc=24'h8569A5.
- Saturation: v_alpha=24'hBE8000 (-1000.0), v_beta=0 -> Ua=24'hA2BF10, sat[0]=1, Ub=Uc=24'h1F4000 (+500.0), sat[2:1]=00.
- Sync gating:
  - Stimulus: accept at T0 with sync pulsed at T2 and T3, then held low for 20 cycles, then pulsed.
  - Required: Ua/Ub/Uc unchanged and in_ready=0 throughout the wait; update only at the final pulse; in_ready=1 afterwards.
- Negative zero: v_alpha=24'h800000, v_beta=24'h800000 -> Ua=Ub=Uc=24'h000000, sat=000.
- Reset mid-op:
  - Stimulus: apply the pure-alpha case, then assert reset in PEND.
  - Required: outputs 0, no update pulse, in_ready=0 during reset and 1 one cycle after release; the next sync produces no update.

Source files
------------

// File: rtl/inv_clarke_pwm_ref.sv
// rtl/inv_clarke_pwm_ref.sv - inverse Clarke transform with phase clamp and sync-gated shadow outputs
// Sign-magnitude alpha/beta in, clamped sign-magnitude Ua/Ub/Uc out, applied only on a carrier sync.
module inv_clarke_pwm_ref #(
  parameter logic [15:0] K_SQRT3_2 = 16'hDDB4,
  parameter logic [22:0] MAG_MAX   = 23'h22BF10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] v_alpha,
  input  logic [23:0] v_beta,
  input  logic        sync,
  output logic [23:0] Ua,
  output logic [23:0] Ub,
  output logic [23:0] Uc,
  output logic        update,
  output logic [2:0]  sat
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MUL  = 3'd1;
  localparam logic [2:0] S_SUM  = 3'd2;
  localparam logic [2:0] S_SAT  = 3'd3;
  localparam logic [2:0] S_PEND = 3'd4;

  logic [2:0]  state;
  logic [23:0] alpha_in;
  logic [23:0] beta_in;
  logic [22:0] kb_mag;
  logic        kb_neg;
  logic [24:0] ub_sum;
  logic [24:0] uc_sum;
  logic [23:0] alpha_s;
  logic [23:0] pend_a;
  logic [23:0] pend_b;
  logic [23:0] pend_c;
  logic [2:0]  pend_sat;

  // Returns {sat, sign, magnitude}; a zero magnitude always comes back positive.
  function automatic logic [24:0] clamp_sm(input logic neg, input logic [23:0] mag);
    logic       over;
    logic [22:0] m;
    over = (mag > {1'b0, MAG_MAX});
    m    = over ? MAG_MAX : mag[22:0];
    return {over, neg & (m != 23'd0), m};
  endfunction

  function automatic logic [23:0] abs25(input logic [24:0] v);
    logic [24:0] n;
    n = -v;
    return v[24] ? n[23:0] : v[23:0];
  endfunction

  logic [38:0] prod;
  logic        unused_prod_lsb;
  assign prod            = {16'd0, beta_in[22:0]} * {23'd0, K_SQRT3_2};
  assign unused_prod_lsb = ^prod[15:0];

  logic [24:0] half25;
  logic [24:0] kb25;
  logic [24:0] neg_half;
  logic [24:0] kb_signed;
  assign half25    = {3'd0, alpha_in[22:1]};
  assign kb25      = {2'd0, kb_mag};
  assign neg_half  = alpha_in[23] ? half25 : -half25;
  assign kb_signed = kb_neg ? -kb25 : kb25;

  logic [24:0] sm_a;
  logic [24:0] sm_b;
  logic [24:0] sm_c;
  assign sm_a = clamp_sm(alpha_s[23], {1'b0, alpha_s[22:0]});
  assign sm_b = clamp_sm(ub_sum[24], abs25(ub_sum));
  assign sm_c = clamp_sm(uc_sum[24], abs25(uc_sum));

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      in_ready <= 1'b0;
      update   <= 1'b0;
      Ua       <= 24'd0;
      Ub       <= 24'd0;
      Uc       <= 24'd0;
      sat      <= 3'b000;
      alpha_in <= 24'd0;
      beta_in  <= 24'd0;
      kb_mag   <= 23'd0;
      kb_neg   <= 1'b0;
      ub_sum   <= 25'd0;
      uc_sum   <= 25'd0;
      alpha_s  <= 24'd0;
      pend_a   <= 24'd0;
      pend_b   <= 24'd0;
      pend_c   <= 24'd0;
      pend_sat <= 3'b000;
    end else begin
      update <= 1'b0;
      case (state)
        S_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            alpha_in <= v_alpha;
            beta_in  <= v_beta;
            in_ready <= 1'b0;
            state    <= S_MUL;
          end
        end
        S_MUL: begin
          kb_mag <= prod[38:16];
          kb_neg <= beta_in[23];
          state  <= S_SUM;
        end
        S_SUM: begin
          ub_sum  <= neg_half + kb_signed;
          uc_sum  <= neg_half - kb_signed;
          alpha_s <= alpha_in;
          state   <= S_SAT;
        end
        S_SAT: begin
          pend_a   <= sm_a[23:0];
          pend_b   <= sm_b[23:0];
          pend_c   <= sm_c[23:0];
          pend_sat <= {sm_c[24], sm_b[24], sm_a[24]};
          state    <= S_PEND;
        end
        S_PEND: begin
          // Only a turning point may move the PWM references.
          if (sync) begin
            Ua       <= pend_a;
            Ub       <= pend_b;
            Uc       <= pend_c;
            sat      <= pend_sat;
            update   <= 1'b1;
            in_ready <= 1'b1;
            state    <= S_IDLE;
          end
        end
        default: begin
          in_ready <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_clarke_pwm_ref.sv
// tb/tb_inv_clarke_pwm_ref.sv - self-checking bench for inv_clarke_pwm_ref
module tb_inv_clarke_pwm_ref;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [23:0] v_alpha;
  logic [23:0] v_beta;
  logic        sync;
  logic [23:0] Ua;
  logic [23:0] Ub;
  logic [23:0] Uc;
  logic        update;
  logic [2:0]  sat;

  int checks   = 0;
  int failures = 0;

  logic [23:0] cur_a = 24'd0;
  logic [23:0] cur_b = 24'd0;
  logic [23:0] cur_c = 24'd0;
  logic [2:0]  cur_s = 3'b000;

  typedef struct {
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] ua;
    logic [23:0] ub;
    logic [23:0] uc;
    logic [2:0]  s;
    int          w;
    bit          early;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  inv_clarke_pwm_ref dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .v_alpha  (v_alpha),
    .v_beta   (v_beta),
    .sync     (sync),
    .Ua       (Ua),
    .Ub       (Ub),
    .Uc       (Uc),
    .update   (update),
    .sat      (sat)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag);
    chk({tag, "_ua"}, {8'd0, Ua}, {8'd0, cur_a});
    chk({tag, "_ub"}, {8'd0, Ub}, {8'd0, cur_b});
    chk({tag, "_uc"}, {8'd0, Uc}, {8'd0, cur_c});
    chk({tag, "_sat"}, {29'd0, sat}, {29'd0, cur_s});
  endtask

  // Signed integer value -> clamped, normalized sign-magnitude.
  function automatic logic [23:0] pack(input longint v, output logic over);
    longint m;
    m    = (v < 0) ? -v : v;
    over = (m > 64'sd2277136);
    if (over) m = 2277136;
    return {(v < 0) && (m != 0), m[22:0]};
  endfunction

  function automatic void model(input logic [23:0] a, input logic [23:0] b,
                                output logic [23:0] ua, output logic [23:0] ub,
                                output logic [23:0] uc, output logic [2:0] s);
    longint am, bm, half, kb, av, hs, ks;
    logic o0, o1, o2;
    am   = longint'(a[22:0]);
    bm   = longint'(b[22:0]);
    av   = a[23] ? -am : am;
    half = am / 2;
    hs   = a[23] ? -half : half;
    kb   = (bm * 56756) / 65536;
    ks   = b[23] ? -kb : kb;
    ua   = pack(av, o0);
    ub   = pack(-hs + ks, o1);
    uc   = pack(-hs - ks, o2);
    s    = {o2, o1, o0};
  endfunction

  task automatic apply(input logic [23:0] a, input logic [23:0] b,
                       input logic [23:0] ea, input logic [23:0] eb,
                       input logic [23:0] ec, input logic [2:0] es,
                       input int w, input bit early);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("ready_wait", {31'd0, in_ready}, 32'd1);
    v_alpha  = a;
    v_beta   = b;
    in_valid = 1'b1;
    tick();
    chk("ready_drop", {31'd0, in_ready}, 32'd0);
    for (int i = 1; i <= w; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      v_alpha  = 24'($urandom);
      v_beta   = 24'($urandom);
      sync     = early && (i == 2 || i == 3);
      tick();
      chk("hold_update", {31'd0, update}, 32'd0);
      chk("hold_ready", {31'd0, in_ready}, 32'd0);
      chk_outs("hold");
    end
    in_valid = 1'b0;
    sync     = 1'b1;
    tick();
    sync  = 1'b0;
    cur_a = ea;
    cur_b = eb;
    cur_c = ec;
    cur_s = es;
    chk("apply_update", {31'd0, update}, 32'd1);
    chk("apply_ready", {31'd0, in_ready}, 32'd1);
    chk_outs("apply");
    tick();
    chk("update_single", {31'd0, update}, 32'd0);
    chk_outs("after");
  endtask

  initial begin
    logic [23:0] ra, rb, ea, eb, ec;
    logic [2:0]  es;

    vecs[0] = '{24'h064000, 24'h000000, 24'h064000, 24'h832000, 24'h832000, 3'b000, 3, 1'b0};
    vecs[1] = '{24'h000000, 24'h064000, 24'h000000, 24'h0569A5, 24'h8569A5, 3'b000, 23, 1'b1};
    vecs[2] = '{24'hBE8000, 24'h000000, 24'hA2BF10, 24'h1F4000, 24'h1F4000, 3'b001, 3, 1'b0};
    vecs[3] = '{24'h800000, 24'h800000, 24'h000000, 24'h000000, 24'h000000, 3'b000, 4, 1'b0};
    vecs[4] = '{24'h000000, 24'h3E8000, 24'h000000, 24'h22BF10, 24'hA2BF10, 3'b110, 3, 1'b1};
    vecs[5] = '{24'h000000, 24'h864000, 24'h000000, 24'h8569A5, 24'h0569A5, 3'b000, 5, 1'b0};
    vecs[6] = '{24'h800001, 24'h000000, 24'h800001, 24'h000000, 24'h000000, 3'b000, 3, 1'b0};
    vecs[7] = '{24'h064000, 24'h000000, 24'h064000, 24'h832000, 24'h832000, 3'b000, 3, 1'b0};

    reset    = 1'b1;
    in_valid = 1'b0;
    sync     = 1'b0;
    v_alpha  = 24'd0;
    v_beta   = 24'd0;
    tick();
    tick();
    tick();
    chk("rst_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_update", {31'd0, update}, 32'd0);
    chk_outs("rst");
    reset = 1'b0;
    chk("rel_ready_low", {31'd0, in_ready}, 32'd0);
    tick();
    chk("rel_ready_high", {31'd0, in_ready}, 32'd1);

    foreach (vecs[i])
      apply(vecs[i].a, vecs[i].b, vecs[i].ua, vecs[i].ub, vecs[i].uc, vecs[i].s,
            vecs[i].w, vecs[i].early);

    // Reset while a result is pending in PEND.
    in_valid = 1'b1;
    v_alpha  = 24'h064000;
    v_beta   = 24'h000000;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    reset = 1'b1;
    tick();
    cur_a = 24'd0;
    cur_b = 24'd0;
    cur_c = 24'd0;
    cur_s = 3'b000;
    chk("midrst_update", {31'd0, update}, 32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd0);
    chk_outs("midrst");
    tick();
    reset = 1'b0;
    chk("midrel_ready_low", {31'd0, in_ready}, 32'd0);
    tick();
    chk("midrel_ready_high", {31'd0, in_ready}, 32'd1);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    chk("midrst_sync_update", {31'd0, update}, 32'd0);
    chk_outs("midrst_sync");
    tick();
    chk("midrst_sync_update2", {31'd0, update}, 32'd0);

    for (int k = 0; k < 40; k++) begin
      if (k % 2 == 0) begin
        ra = 24'($urandom);
        rb = 24'($urandom);
      end else begin
        ra = {1'($urandom_range(0, 1)), 23'($urandom_range(0, 24'h300000))};
        rb = {1'($urandom_range(0, 1)), 23'($urandom_range(0, 24'h300000))};
      end
      model(ra, rb, ea, eb, ec, es);
      apply(ra, rb, ea, eb, ec, es, $urandom_range(3, 6), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
